chad_stack: RTL and testbench

Parametrised circular hardware stack used by the chad core for its data and return stacks, with explicit depth tracking and overflow/underflow detection. It holds every entry below the core's top-of-stack register (T lives in the core), accepts one push, pop, double pop or replace per cycle, and exposes the top two stored entries (N and NN) combinationally. Stack-fault detection can be compiled in or out with one macro.

---
 rtl/chad_stack.sv | 95 +++++++++
 tb/tb_chad_stack.sv | 116 +++++++++++
 2 files changed

// File: rtl/chad_stack.sv
// chad_stack: circular data/return stack holding everything below T, with depth tracking.
// Define CHAD_STACK_GUARD_EN to build the sticky ovf/unf flags and the err strobe.
module chad_stack #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 20
) (
  input  logic                     clk,
  input  logic                     resetq,
  input  logic                     hold,
  input  logic                     we,
  input  logic [WIDTH-1:0]         wd,
  input  logic [1:0]               delta,
  output logic [WIDTH-1:0]         rd0,
  output logic [WIDTH-1:0]         rd1,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  input  logic                     clr,
  output logic                     ovf,
  output logic                     unf,
  output logic                     err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] SP_TOP = PW'(DEPTH - 1);
  localparam logic [PW-1:0] SP_ONE = PW'(1);
  localparam logic [PW-1:0] SP_TWO = PW'(2);
  localparam logic [PW-1:0] SP_WRAP2 = PW'(DEPTH - 2);
  localparam logic [PW:0] D_MAX = (PW+1)'(DEPTH);
  localparam logic [PW:0] D_ONE = (PW+1)'(1);
  localparam logic [PW:0] D_TWO = (PW+1)'(2);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] sp_q, sp_d, sp_next, sp_inc, sp_dec, sp_dec2;
  logic [PW:0] depth_q, depth_d, depth_next;
  logic push, pop1, pop2, over, under;
  always_comb begin
    push = delta == 2'b01;
    pop1 = delta == 2'b11;
    pop2 = delta == 2'b10;
    sp_inc = sp_q == SP_TOP ? '0 : sp_q + SP_ONE;
    sp_dec = sp_q == '0 ? SP_TOP : sp_q - SP_ONE;
    sp_dec2 = sp_q < SP_TWO ? sp_q + SP_WRAP2 : sp_q - SP_TWO;
    sp_next = push ? sp_inc : pop1 ? sp_dec : pop2 ? sp_dec2 : sp_q;
    over = push && full;
    under = (pop1 && depth_q == '0) || (pop2 && depth_q < D_TWO);
    depth_next = push ? (over ? D_MAX : depth_q + D_ONE)
               : pop1 ? (under ? '0 : depth_q - D_ONE)
               : pop2 ? (under ? '0 : depth_q - D_TWO)
               : depth_q;
    sp_d = hold ? sp_q : sp_next;
    depth_d = hold ? depth_q : depth_next;
  end
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      sp_q <= '0;
      depth_q <= '0;
    end else begin
      sp_q <= sp_d;
      depth_q <= depth_d;
    end
  // Storage is deliberately unreset; only the pointer and depth define validity.
  always_ff @(posedge clk)
    if (!hold && we) mem[sp_next] <= wd;
  assign rd0 = mem[sp_q];
  assign rd1 = mem[sp_dec];
  assign depth = depth_q;
  assign empty = depth_q == '0;
  assign full = depth_q == D_MAX;
`ifdef CHAD_STACK_GUARD_EN
  logic ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
  always_comb begin
    ovf_d = (ovf_q && !clr) || (!hold && over);
    unf_d = (unf_q && !clr) || (!hold && under);
    err_d = !hold && (over || under);
  end
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      err_q <= err_d;
    end
  assign ovf = ovf_q;
  assign unf = unf_q;
  assign err = err_q;
`else
  logic unused_guard;
  assign unused_guard = clr;
  assign ovf = 1'b0;
  assign unf = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_chad_stack.sv
// tb_chad_stack: directed stimulus with a queue-based scoreboard checked once per cycle by a monitor.
module tb_chad_stack;
`ifdef CHAD_STACK_GUARD_EN
  localparam logic G = 1'b1;
`else
  localparam logic G = 1'b0;
`endif
  logic clk = 0, resetq = 0, hold = 0, we = 0, clr = 0;
  logic [17:0] wd = '0;
  logic [1:0] delta = '0;
  logic [17:0] rd0, rd1;
  logic [5:0] depth;
  logic empty, full, ovf, unf, err;
  int checks = 0, failures = 0;

  typedef struct packed {
    logic m0, m1;
    logic [17:0] r0, r1;
    logic [5:0] d;
    logic e, f, o, u, er;
  } exp_t;
  exp_t q[$];
  string nq[$];

  chad_stack dut (.clk(clk), .resetq(resetq), .hold(hold), .we(we), .wd(wd), .delta(delta),
                  .rd0(rd0), .rd1(rd1), .depth(depth), .empty(empty), .full(full),
                  .clr(clr), .ovf(ovf), .unf(unf), .err(err));

  always #5 clk = ~clk;

  task automatic cyc(input logic w, input logic [1:0] dl, input logic [17:0] d,
                     input logic h = 0, input logic c = 0);
    @(negedge clk);
    we = w; delta = dl; wd = d; hold = h; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string n, input logic m0, input logic [17:0] r0,
                    input logic m1, input logic [17:0] r1, input int d,
                    input logic o, input logic u, input logic er);
    exp_t e;
    e.m0 = m0; e.r0 = r0; e.m1 = m1; e.r1 = r1; e.d = 6'(d);
    e.e = d == 0; e.f = d == 20; e.o = o; e.u = u; e.er = er;
    q.push_back(e);
    nq.push_back(n);
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      string n;
      e = q.pop_front();
      n = nq.pop_front();
      checks++;
      if ((e.m0 && rd0 !== e.r0) || (e.m1 && rd1 !== e.r1) || depth !== e.d ||
          empty !== e.e || full !== e.f || ovf !== e.o || unf !== e.u || err !== e.er) begin
        failures++;
        $display("FAIL %s: got rd0=%h rd1=%h depth=%0d empty=%b full=%b ovf=%b unf=%b err=%b; want rd0=%h(chk %b) rd1=%h(chk %b) depth=%0d empty=%b full=%b ovf=%b unf=%b err=%b",
                 n, rd0, rd1, depth, empty, full, ovf, unf, err,
                 e.r0, e.m0, e.r1, e.m1, e.d, e.e, e.f, e.o, e.u, e.er);
      end
    end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    ex("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    resetq = 1;
    cyc(1, 2'b01, 18'h00001); ex("push1", 1, 18'h00001, 0, 0, 1, 0, 0, 0);
    cyc(1, 2'b01, 18'h00002); ex("push2", 1, 18'h00002, 1, 18'h00001, 2, 0, 0, 0);
    cyc(1, 2'b01, 18'h00003); ex("push3", 1, 18'h00003, 1, 18'h00002, 3, 0, 0, 0);
    cyc(1, 2'b00, 18'h00033); ex("replace", 1, 18'h00033, 1, 18'h00002, 3, 0, 0, 0);
    cyc(0, 2'b10, 18'h0); ex("dpop", 1, 18'h00001, 0, 0, 1, 0, 0, 0);
    cyc(0, 2'b10, 18'h0); ex("dpop_unf", 0, 0, 0, 0, 0, 0, G, G);
    cyc(0, 2'b00, 18'h0); ex("err_drop", 0, 0, 0, 0, 0, 0, G, 0);
    cyc(0, 2'b00, 18'h0, 0, 1); ex("clr_unf", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 20; i++) begin
      cyc(1, 2'b01, 18'h00100 + 18'(i));
      ex($sformatf("fill%0d", i), 1, 18'h00100 + 18'(i), i >= 1, 18'h000ff + 18'(i),
         i >= 19 ? 20 : i + 1, i == 20 ? G : 1'b0, 0, i == 20 ? G : 1'b0);
    end
    cyc(1, 2'b01, 18'h3abcd, 1); ex("hold_push", 1, 18'h00114, 1, 18'h00113, 20, G, 0, 0);
    cyc(1, 2'b00, 18'h3abcd, 1); ex("hold_repl", 1, 18'h00114, 1, 18'h00113, 20, G, 0, 0);
    cyc(1, 2'b01, 18'h3abcd, 1, 1); ex("hold_clr", 1, 18'h00114, 1, 18'h00113, 20, 0, 0, 0);
    cyc(0, 2'b11, 18'h0); ex("pop_after_hold", 1, 18'h00113, 1, 18'h00112, 19, 0, 0, 0);
    @(negedge clk);
    resetq = 0;
    #1;
    ex("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    resetq = 1;
    cyc(0, 2'b10, 18'h0); ex("dpop_empty", 0, 0, 0, 0, 0, 0, G, G);
    cyc(1, 2'b01, 18'h0aaaa); ex("pushA", 1, 18'h0aaaa, 0, 0, 1, 0, G, 0);
    cyc(1, 2'b01, 18'h0bbbb, 0, 1); ex("pushB_clr", 1, 18'h0bbbb, 1, 18'h0aaaa, 2, 0, 0, 0);
    cyc(1, 2'b11, 18'h3ffff); ex("nip_wrap", 1, 18'h3ffff, 0, 0, 1, 0, 0, 0);
    cyc(0, 2'b10, 18'h0, 0, 1); ex("clr_vs_unf", 0, 0, 0, 0, 0, 0, G, G);
    cyc(0, 2'b00, 18'h0); ex("unf_sticky", 0, 0, 0, 0, 0, 0, G, 0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
